latch_rf_write_sched: RTL and testbench



---
 rtl/latch_rf_write_sched.sv | 159 +++++++++++++++
 tb/tb_latch_rf_write_sched.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/latch_rf_write_sched.sv
// Write scheduler for a latch-based register file.
// Round-robin arbitrates NREQ requesters onto one shared write port and runs
// each write as SETUP -> ENABLE (EN_CYCLES) -> HOLD. LAT_D and LAT_EN are
// both driven directly from flops, so decode glitches never reach a latch.
module latch_rf_write_sched #(
  parameter int NREQ      = 4,
  parameter int AW        = 3,
  parameter int DW        = 8,
  parameter int EN_CYCLES = 1
) (
  input  logic                      CLK,
  input  logic                      RSTB,
  input  logic [NREQ-1:0]           REQ_VALID,
  input  logic [NREQ*AW-1:0]        REQ_ADDR,
  input  logic [NREQ*DW-1:0]        REQ_DATA,
  output logic [NREQ-1:0]           REQ_READY,
  output logic [DW-1:0]             LAT_D,
  output logic [(1<<AW)-1:0]        LAT_EN,
  output logic                      BUSY,
  output logic [$clog2(NREQ)-1:0]   GRANT_ID
);

  localparam int GW    = $clog2(NREQ);
  localparam int GW1   = GW + 1;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ENABLE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  state_t            state_reg,  state_next;
  logic [GW-1:0]     rr_ptr_reg, rr_ptr_next;
  logic [GW-1:0]     grant_reg,  grant_next;
  logic [AW-1:0]     addr_reg,   addr_next;
  logic [DW-1:0]     lat_d_reg,  lat_d_next;
  logic [DEPTH-1:0]  lat_en_reg, lat_en_next;
  logic [3:0]        cnt_reg,    cnt_next;

  logic [AW-1:0]     req_addr_arr [NREQ];
  logic [DW-1:0]     req_data_arr [NREQ];

  logic              win_found;
  logic [GW-1:0]     win_idx;
  logic [GW1-1:0]    scan_sum;
  logic [GW-1:0]     scan_idx;
  logic [GW1-1:0]    ptr_inc;
  logic [GW-1:0]     ptr_after_win;

  // Unpack the flat request buses into per-requester words.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign req_addr_arr[gi] = REQ_ADDR[gi*AW +: AW];
      assign req_data_arr[gi] = REQ_DATA[gi*DW +: DW];
    end
  endgenerate

  // Round-robin search: scan offsets high-to-low so the lowest offset from rr_ptr wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      scan_sum = {1'b0, rr_ptr_reg} + GW1'(i);
      if (scan_sum >= GW1'(NREQ)) begin
        scan_sum = scan_sum - GW1'(NREQ);
      end
      scan_idx = scan_sum[GW-1:0];
      if (REQ_VALID[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // Pointer for the next round: one past the winner, wrapping at NREQ.
  always_comb begin
    ptr_inc = {1'b0, win_idx} + GW1'(1);
    if (ptr_inc >= GW1'(NREQ)) begin
      ptr_inc = '0;
    end
    ptr_after_win = ptr_inc[GW-1:0];
  end

  // Next-state logic; LAT_EN is precomputed here so it can leave a flop.
  always_comb begin
    state_next  = state_reg;
    rr_ptr_next = rr_ptr_reg;
    grant_next  = grant_reg;
    addr_next   = addr_reg;
    lat_d_next  = lat_d_reg;
    lat_en_next = '0;
    cnt_next    = cnt_reg;
    REQ_READY   = '0;
    case (state_reg)
      ST_IDLE: begin
        if (win_found) begin
          REQ_READY[win_idx] = 1'b1;
          addr_next   = req_addr_arr[win_idx];
          lat_d_next  = req_data_arr[win_idx];
          grant_next  = win_idx;
          rr_ptr_next = ptr_after_win;
          state_next  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        lat_en_next[addr_reg] = 1'b1;
        cnt_next   = '0;
        state_next = ST_ENABLE;
      end
      ST_ENABLE: begin
        if (cnt_reg == 4'(EN_CYCLES - 1)) begin
          cnt_next   = '0;
          state_next = ST_HOLD;
        end else begin
          cnt_next = cnt_reg + 4'd1;
          lat_en_next[addr_reg] = 1'b1;
        end
      end
      ST_HOLD: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset clears LAT_EN immediately.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state_reg  <= ST_IDLE;
      rr_ptr_reg <= '0;
      grant_reg  <= '0;
      addr_reg   <= '0;
      lat_d_reg  <= '0;
      lat_en_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      rr_ptr_reg <= rr_ptr_next;
      grant_reg  <= grant_next;
      addr_reg   <= addr_next;
      lat_d_reg  <= lat_d_next;
      lat_en_reg <= lat_en_next;
      cnt_reg    <= cnt_next;
    end
  end

  assign LAT_D    = lat_d_reg;
  assign LAT_EN   = lat_en_reg;
  assign BUSY     = (state_reg != ST_IDLE);
  assign GRANT_ID = grant_reg;

endmodule

// File: tb/tb_latch_rf_write_sched.sv
// Bench for latch_rf_write_sched: two instances (EN_CYCLES=1 and 3) checked
// every cycle against a transaction-timer model, plus directed literal checks.
module tb_latch_rf_write_sched;

  logic        CLK;
  logic        RSTB;

  logic [3:0]  va, vb;
  logic [11:0] aa, ab;
  logic [31:0] da, db;
  logic [3:0]  rdy_a, rdy_b;
  logic [7:0]  ld_a, ld_b, le_a, le_b;
  logic        busy_a, busy_b;
  logic [1:0]  gid_a, gid_b;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [3:0] acc_a;
  bit         auto_drop;
  int         log_id[$];
  int         log_cyc[$];

  // Model state per instance
  int         en_c    [2];
  int         m_timer [2];
  int         m_ptr   [2];
  int         m_grant [2];
  logic [2:0] m_addr  [2];
  logic [7:0] m_data  [2];
  logic [7:0] prev_le [2];
  logic [7:0] prev_ld [2];

  latch_rf_write_sched #(.NREQ(4), .AW(3), .DW(8), .EN_CYCLES(1)) dut_a (
    .CLK(CLK), .RSTB(RSTB), .REQ_VALID(va), .REQ_ADDR(aa), .REQ_DATA(da),
    .REQ_READY(rdy_a), .LAT_D(ld_a), .LAT_EN(le_a), .BUSY(busy_a), .GRANT_ID(gid_a)
  );

  latch_rf_write_sched #(.NREQ(4), .AW(3), .DW(8), .EN_CYCLES(3)) dut_b (
    .CLK(CLK), .RSTB(RSTB), .REQ_VALID(vb), .REQ_ADDR(ab), .REQ_DATA(db),
    .REQ_READY(rdy_b), .LAT_D(ld_b), .LAT_EN(le_b), .BUSY(busy_b), .GRANT_ID(gid_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int pick(input int ptr, input logic [3:0] v);
    for (int i = 0; i < 4; i++) begin
      if (v[(ptr + i) % 4]) return (ptr + i) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset(input int k);
    m_timer[k] = 0; m_ptr[k] = 0; m_grant[k] = 0;
    m_addr[k]  = '0; m_data[k] = '0; prev_le[k] = '0; prev_ld[k] = '0;
  endtask

  // Check one instance against the model, then advance the model past the next edge.
  task automatic step_model(input int k, input logic [3:0] v, input logic [11:0] a,
                            input logic [31:0] d, input logic [3:0] rdy,
                            input logic [7:0] ld, input logic [7:0] le,
                            input logic bsy, input logic [1:0] gid);
    int w, el, len;
    logic [3:0] er;
    logic [7:0] ee;
    len = 2 + en_c[k];
    w   = pick(m_ptr[k], v);
    er  = '0;
    ee  = '0;
    if (m_timer[k] == 0) begin
      if (w >= 0) er = 4'(1 << w);
    end else begin
      el = len - m_timer[k];
      if (el >= 1 && el <= en_c[k]) ee = 8'(1 << m_addr[k]);
    end
    chk($sformatf("ready%0d", k), 32'(rdy), 32'(er));
    chk($sformatf("lat_en%0d", k), 32'(le), 32'(ee));
    chk($sformatf("lat_d%0d", k), 32'(ld), 32'(m_data[k]));
    chk($sformatf("busy%0d", k), 32'(bsy), 32'(m_timer[k] != 0));
    chk($sformatf("grant_id%0d", k), 32'(gid), 32'(m_grant[k]));
    chk($sformatf("onehot%0d", k), 32'($countones(le) <= 1), 32'd1);
    if (prev_le[k] != 0) chk($sformatf("ld_stable%0d", k), 32'(ld), 32'(prev_ld[k]));
    prev_le[k] = le;
    prev_ld[k] = ld;
    if (m_timer[k] > 0) begin
      m_timer[k]--;
    end else if (w >= 0) begin
      m_addr[k]  = a[w*3 +: 3];
      m_data[k]  = d[w*8 +: 8];
      m_grant[k] = w;
      m_ptr[k]   = (w + 1) % 4;
      m_timer[k] = len;
    end
  endtask

  // Compare process: outputs are checked on the falling edge.
  always @(negedge CLK) begin
    if (!RSTB) begin
      for (int k = 0; k < 2; k++) model_reset(k);
      chk("rst_ready", 32'({rdy_b, rdy_a}), 32'd0);
      chk("rst_lat_en", 32'({le_b, le_a}), 32'd0);
      chk("rst_lat_d", 32'({ld_b, ld_a}), 32'd0);
      chk("rst_busy", 32'({busy_b, busy_a}), 32'd0);
      chk("rst_gid", 32'({gid_b, gid_a}), 32'd0);
    end else begin
      step_model(0, va, aa, da, rdy_a, ld_a, le_a, busy_a, gid_a);
      step_model(1, vb, ab, db, rdy_b, ld_b, le_b, busy_b, gid_b);
    end
  end

  // Acceptance log for instance A.
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    acc_a <= RSTB ? (va & rdy_a) : 4'd0;
    if (RSTB) begin
      for (int k = 0; k < 4; k++) begin
        if (va[k] && rdy_a[k]) begin
          log_id.push_back(k);
          log_cyc.push_back(cyc);
          $display("grant: req%0d accepted at cycle %0d addr=%0d data=%02h",
                   k, cyc, aa[k*3 +: 3], da[k*8 +: 8]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #2;
    if (auto_drop) va = va & ~acc_a;
  endtask

  initial begin
    int n80, nb;
    en_c[0] = 1;
    en_c[1] = 3;
    auto_drop = 1'b0;
    RSTB = 1'b0;
    va = '0; vb = '0; aa = '0; ab = '0; da = '0; db = '0;
    tick(); tick();
    RSTB = 1'b1;
    tick();

    // Reset mid-ENABLE: write to word 5, then pull RSTB between edges.
    va = 4'b0100; aa[8:6] = 3'd5; da[23:16] = 8'h5A;
    #1 chk("rst_test_ready", 32'(rdy_a), 32'h4);
    tick();
    va = '0;
    tick();
    chk("rst_test_en_before", 32'(le_a), 32'h20);
    #1 RSTB = 1'b0;
    #1 chk("rst_test_en_async", 32'(le_a), 32'h0);
    tick(); tick();
    RSTB = 1'b1;
    #1;
    chk("post_rst_busy", 32'(busy_a), 32'd0);
    chk("post_rst_gid", 32'(gid_a), 32'd0);
    chk("post_rst_ready", 32'(rdy_a), 32'd0);
    tick();

    // Round-robin with all requesters held valid.
    log_id.delete(); log_cyc.delete();
    aa = {3'd6, 3'd4, 3'd2, 3'd1};
    da = 32'h44332211;
    va = 4'hF;
    for (int t = 0; t < 60 && log_id.size() < 5; t++) tick();
    va = '0;
    chk("rr_count", 32'(log_id.size()), 32'd5);
    if (log_id.size() >= 5) begin
      chk("rr_g0", 32'(log_id[0]), 32'd0);
      chk("rr_g1", 32'(log_id[1]), 32'd1);
      chk("rr_g2", 32'(log_id[2]), 32'd2);
      chk("rr_g3", 32'(log_id[3]), 32'd3);
      chk("rr_g4", 32'(log_id[4]), 32'd0);
      for (int i = 0; i < 4; i++)
        chk($sformatf("rr_gap%0d", i), 32'(log_cyc[i+1] - log_cyc[i]), 32'd4);
    end
    for (int t = 0; t < 20 && busy_a; t++) tick();
    chk("rr_idle", 32'(busy_a), 32'd0);
    tick();

    // Single write: req1, addr 3, data A5.
    aa[5:3] = 3'd3; da[15:8] = 8'hA5;
    va = 4'b0010;
    #1 chk("sw_c0_ready", 32'(rdy_a), 32'h2);
    tick();
    va = '0;
    #1;
    chk("sw_c1_ld", 32'(ld_a), 32'hA5);
    chk("sw_c1_en", 32'(le_a), 32'h0);
    chk("sw_c1_gid", 32'(gid_a), 32'd1);
    tick();
    chk("sw_c2_en", 32'(le_a), 32'h08);
    tick();
    chk("sw_c3_en", 32'(le_a), 32'h0);
    chk("sw_c3_ld", 32'(ld_a), 32'hA5);
    chk("sw_c3_busy", 32'(busy_a), 32'd1);
    tick();
    chk("sw_c4_busy", 32'(busy_a), 32'd0);
    tick();

    // Boundary: req3, then wrap to req0, then req2; req1 drops before any grant.
    log_id.delete(); log_cyc.delete();
    auto_drop = 1'b1;
    aa[11:9] = 3'd2; da[31:24] = 8'h77;
    aa[2:0]  = 3'd0; da[7:0]   = 8'h0F;
    aa[8:6]  = 3'd7; da[23:16] = 8'hC3;
    va = 4'b1000;
    #1 chk("bd_ready3", 32'(rdy_a), 32'h8);
    tick();
    tick();
    va = va | 4'b0010;
    tick();
    va = (va & ~4'b0010) | 4'b0101;
    for (int t = 0; t < 40 && log_id.size() < 3; t++) tick();
    for (int t = 0; t < 20 && busy_a; t++) tick();
    chk("bd_count", 32'(log_id.size()), 32'd3);
    if (log_id.size() >= 3) begin
      chk("bd_g0", 32'(log_id[0]), 32'd3);
      chk("bd_g1", 32'(log_id[1]), 32'd0);
      chk("bd_g2", 32'(log_id[2]), 32'd2);
    end
    chk("bd_last_ld", 32'(ld_a), 32'hC3);
    auto_drop = 1'b0;
    va = '0;
    tick();

    // Stretched enable on the EN_CYCLES=3 instance: addr 7.
    ab[2:0] = 3'd7; db[7:0] = 8'h3C;
    vb = 4'b0001;
    #1 chk("st_ready", 32'(rdy_b), 32'h1);
    tick();
    vb = '0;
    n80 = 0; nb = 0;
    for (int i = 0; i < 5; i++) begin
      if (le_b == 8'h80) n80++;
      if (busy_b) nb++;
      tick();
    end
    chk("st_en_cycles", 32'(n80), 32'd3);
    chk("st_busy_cycles", 32'(nb), 32'd5);
    chk("st_done", 32'(busy_b), 32'd0);
    chk("st_ld", 32'(ld_b), 32'h3C);
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
